snake_head_stepper: RTL



---
 rtl/snake_head_stepper_pkg.sv | 27 ++
 rtl/snake_head_stepper_game_tick_gen.sv | 29 ++
 rtl/snake_head_stepper.sv | 98 +++++++++
 3 files changed

// File: rtl/snake_head_stepper_pkg.sv
// rtl/snake_head_stepper_pkg.sv - shared direction, state and grid constants
package snake_head_stepper_pkg;

  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_DOWN  = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam int DEF_GRID_W  = 160;
  localparam int DEF_GRID_H  = 120;
  localparam int DEF_START_X = 80;
  localparam int DEF_START_Y = 60;

  function automatic logic dir_vertical(input logic [2:0] d);
    return d[2];
  endfunction

  // Down or right: the coordinate grows.
  function automatic logic dir_positive(input logic [2:0] d);
    return d[2] ? d[1] : d[0];
  endfunction

endpackage

// File: rtl/snake_head_stepper_game_tick_gen.sv
// rtl/snake_head_stepper_game_tick_gen.sv - free-running divider giving one tick per game step
module game_tick_gen
  import snake_head_stepper_pkg::*;
#(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// rtl/snake_head_stepper.sv - advances the snake head once per game tick and detects wall hits
module snake_head_stepper
  import snake_head_stepper_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int START_X  = DEF_START_X,
  parameter int START_Y  = DEF_START_Y,
  parameter int TICK_DIV = 5000000,
  parameter int WRAP     = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2:0]     dir_in,
  input  logic           dir_valid,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic           step,
  output logic           running,
  output logic           game_over
);

  localparam logic [X_W:0] X_LAST = (X_W + 1)'(GRID_W - 1);
  localparam logic [Y_W:0] Y_LAST = (Y_W + 1)'(GRID_H - 1);

  logic [1:0]     state;
  logic [2:0]     dir_q;
  logic           tick;
  logic [X_W:0]   x_cand;
  logic [Y_W:0]   y_cand;
  logic           hit;
  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ST_RUN),
    .clear  (state != ST_RUN),
    .tick   (tick)
  );

  // One extra bit so that 0-1 lands above the last legal cell and reads as a hit.
  always_comb begin
    x_cand = {1'b0, head_x};
    y_cand = {1'b0, head_y};
    hit    = 1'b0;
    x_next = head_x;
    y_next = head_y;
    if (dir_vertical(dir_q)) begin
      y_cand = dir_positive(dir_q) ? y_cand + 1'b1 : y_cand - 1'b1;
      hit    = y_cand > Y_LAST;
      if (hit) y_next = dir_positive(dir_q) ? '0 : Y_LAST[Y_W-1:0];
      else     y_next = y_cand[Y_W-1:0];
    end else begin
      x_cand = dir_positive(dir_q) ? x_cand + 1'b1 : x_cand - 1'b1;
      hit    = x_cand > X_LAST;
      if (hit) x_next = dir_positive(dir_q) ? '0 : X_LAST[X_W-1:0];
      else     x_next = x_cand[X_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      dir_q  <= DIR_LEFT;
      head_x <= X_W'(START_X);
      head_y <= Y_W'(START_Y);
      step   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (dir_valid) dir_q <= dir_in;
      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN: begin
          if (tick) begin
            if (hit && (WRAP == 0)) begin
              state <= ST_DEAD;
            end else begin
              head_x <= x_next;
              head_y <= y_next;
              step   <= 1'b1;
            end
          end
        end
        ST_DEAD: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign running   = (state == ST_RUN);
  assign game_over = (state == ST_DEAD);

endmodule
